// File: rtl/wca_reg_pkg.sv
// Shared types and constants for the 8-bit register read path.
package wca_reg_pkg;

    localparam int WCA_REG_WIDTH = 8;
    localparam logic [WCA_REG_WIDTH-1:0] RD_RST_DATA = 8'h00;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic                     err;
        logic [WCA_REG_WIDTH-1:0] dat;
    } rd_beat_t;

endpackage

// File: rtl/wca_reg_reader_if.sv
// Host read channel: request with start address/length, byte stream back with valid/ready.
interface wca_reg_reader_if #(
    parameter int AW = 4,
    parameter int LW = 4
) ();
    logic          req;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          busy;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic          last;
    logic          err;

    modport master (
        output req, addr, len, ready,
        input  busy, data, valid, last, err
    );

    modport slave (
        input  req, addr, len, ready,
        output busy, data, valid, last, err
    );
endinterface

// File: rtl/wca_reg_byte_sel.sv
// Combinational NREGS-way byte mux with range check; out-of-range addresses return zero with err set.
module wca_reg_byte_sel
    import wca_reg_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic [NREGS*WCA_REG_WIDTH-1:0] bank,
    input  logic [AW-1:0]                  addr,
    output rd_beat_t                       beat
);

    // Explicit compare per register keeps out-of-range addresses free of X.
    always_comb begin
        beat.dat = RD_RST_DATA;
        beat.err = (32'(addr) >= NREGS);
        for (int k = 0; k < NREGS; k++) begin
            if (addr == AW'(k)) begin
                beat.dat = bank[k*WCA_REG_WIDTH +: WCA_REG_WIDTH];
            end
        end
    end

endmodule

// File: rtl/wca_reg_reader.sv
// Snapshot-based register bank reader serving single and burst byte reads.
// First beat two clocks after accept; outputs hold while ready is low; requests while busy are dropped.
module wca_reg_reader
    import wca_reg_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int LW    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREGS*WCA_REG_WIDTH-1:0] reg_q,
    wca_reg_reader_if.slave                rd
);

    rd_state_t                      state;
    logic [NREGS*WCA_REG_WIDTH-1:0] snap;
    logic [AW-1:0]                  addr_q;
    logic [LW-1:0]                  cnt_q;
    logic [WCA_REG_WIDTH-1:0]       data_q;
    logic                           valid_q;
    logic                           last_q;
    logic                           err_q;
    logic                           busy_q;

    logic [AW-1:0] sel_addr;
    rd_beat_t      sel_beat;

    // In STREAM the mux looks one address ahead so the next byte lands on the same edge as the beat.
    assign sel_addr = (state == RD_STREAM) ? addr_q + AW'(1) : addr_q;

    wca_reg_byte_sel #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_byte_sel (
        .bank (snap),
        .addr (sel_addr),
        .beat (sel_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            snap    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= RD_RST_DATA;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (rd.req) begin
                        snap   <= reg_q;
                        addr_q <= rd.addr;
                        cnt_q  <= rd.len;
                        busy_q <= 1'b1;
                        state  <= RD_LOAD;
                    end
                end
                RD_LOAD: begin
                    data_q  <= sel_beat.dat;
                    err_q   <= sel_beat.err;
                    last_q  <= (cnt_q == '0);
                    valid_q <= 1'b1;
                    state   <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (valid_q && rd.ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= RD_IDLE;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                            cnt_q  <= cnt_q - LW'(1);
                            data_q <= sel_beat.dat;
                            err_q  <= sel_beat.err;
                            last_q <= (cnt_q == LW'(1));
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    assign rd.busy  = busy_q;
    assign rd.data  = data_q;
    assign rd.valid = valid_q;
    assign rd.last  = last_q;
    assign rd.err   = err_q;

endmodule

// File: tb/tb_wca_reg_reader.sv
// Directed bench for wca_reg_reader with a queue scoreboard and a negedge beat monitor.
module tb_wca_reg_reader;

    localparam int NREGS = 12;
    localparam int AW    = 4;
    localparam int LW    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREGS*8-1:0]   reg_q;

    always #5 clk = ~clk;

    wca_reg_reader_if #(.AW(AW), .LW(LW)) rd ();

    wca_reg_reader #(.NREGS(NREGS), .AW(AW), .LW(LW)) dut (
        .clk   (clk),
        .rst   (rst),
        .reg_q (reg_q),
        .rd    (rd)
    );

    typedef struct {
        logic [7:0] dat;
        logic       err;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic e, input logic l);
        exp_t x;
        x.dat  = d;
        x.err  = e;
        x.last = l;
        exp_q.push_back(x);
    endtask

    task automatic set_reg(input int k, input logic [7:0] v);
        reg_q[k*8 +: 8] = v;
    endtask

    // Returns just after the accepting edge (state was IDLE on entry).
    task automatic start(input logic [3:0] a, input logic [3:0] l);
        @(posedge clk); #1;
        rd.req  = 1'b1;
        rd.addr = a;
        rd.len  = l;
        @(posedge clk); #1;
        rd.req  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rd.busy || exp_q.size() != 0) && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd.busy || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_idle: busy=%0b pending=%0d expected busy=0 pending=0", name, rd.busy, exp_q.size());
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n = 0;
        while (rd.busy !== lvl && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rd.busy), 32'(lvl));
    endtask

    // Scoreboard monitor: a beat is valid&ready at the negedge before the consuming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rd.valid && rd.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", rd.data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(rd.data), 32'(e.dat));
                check("beat_err",  32'(rd.err),  32'(e.err));
                check("beat_last", 32'(rd.last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cyc;
        int valid_cyc;
        logic done;

        rst      = 1'b1;
        rd.req   = 1'b0;
        rd.addr  = '0;
        rd.len   = '0;
        rd.ready = 1'b1;
        reg_q    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(rd.valid), 32'd0);
        check("rst_busy",  32'(rd.busy),  32'd0);
        check("rst_data",  32'(rd.data),  32'h00);
        check("rst_last",  32'(rd.last),  32'd0);
        check("rst_err",   32'(rd.err),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single byte read, latency and busy drop.
        set_reg(3, 8'hA5);
        push_exp(8'hA5, 1'b0, 1'b1);
        start(4'd3, 4'd0);
        @(negedge clk);
        check("t1_load_valid", 32'(rd.valid), 32'd0);
        check("t1_load_busy",  32'(rd.busy),  32'd1);
        @(negedge clk);
        check("t1_beat_valid", 32'(rd.valid), 32'd1);
        @(negedge clk);
        check("t1_done_busy",  32'(rd.busy),  32'd0);
        check("t1_done_valid", 32'(rd.valid), 32'd0);
        wait_idle("t1");

        // Four-beat burst, no bubbles.
        set_reg(0, 8'h11);
        set_reg(1, 8'h22);
        set_reg(2, 8'h33);
        set_reg(3, 8'h44);
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0);
        push_exp(8'h33, 1'b0, 1'b0);
        push_exp(8'h44, 1'b0, 1'b1);
        start(4'd0, 4'd3);
        busy_cyc  = 0;
        valid_cyc = 0;
        done      = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!rd.busy) begin
                done = 1'b1;
            end else begin
                busy_cyc++;
                if (rd.valid) valid_cyc++;
            end
        end
        check("t2_busy_cycles",  32'(busy_cyc),  32'd5);
        check("t2_valid_cycles", 32'(valid_cyc), 32'd4);
        wait_idle("t2");

        // Backpressure on beat 2 and snapshot coherency.
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0);
        push_exp(8'h33, 1'b0, 1'b0);
        push_exp(8'h44, 1'b0, 1'b1);
        start(4'd0, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd.ready = 1'b0;
        set_reg(2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_data",  32'(rd.data),  32'h22);
            check("t3_hold_valid", 32'(rd.valid), 32'd1);
            check("t3_hold_last",  32'(rd.last),  32'd0);
            @(posedge clk); #1;
        end
        rd.ready = 1'b1;
        @(negedge clk);
        check("t3_release_data", 32'(rd.data), 32'h22);
        wait_idle("t3");

        // Out-of-range beats and address wrap with NREGS=12.
        for (int k = 0; k < NREGS; k++) set_reg(k, 8'hA0 + 8'(k));
        push_exp(8'hAA, 1'b0, 1'b0);
        push_exp(8'hAB, 1'b0, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'h00, 1'b1, 1'b0);
        push_exp(8'hA0, 1'b0, 1'b0);
        push_exp(8'hA1, 1'b0, 1'b1);
        start(4'd10, 4'd7);
        wait_idle("t4");

        // Request pulsed mid-burst is dropped.
        push_exp(8'hA0, 1'b0, 1'b0);
        push_exp(8'hA1, 1'b0, 1'b0);
        push_exp(8'hA2, 1'b0, 1'b0);
        push_exp(8'hA3, 1'b0, 1'b1);
        start(4'd0, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd.req  = 1'b1;
        rd.addr = 4'd5;
        rd.len  = 4'd0;
        @(posedge clk); #1;
        rd.req  = 1'b0;
        wait_idle("t5a");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_requeue", 32'(rd.busy), 32'd0);
        end

        // Request held high re-arms one cycle after busy falls.
        push_exp(8'hA2, 1'b0, 1'b0);
        push_exp(8'hA3, 1'b0, 1'b1);
        push_exp(8'hA2, 1'b0, 1'b0);
        push_exp(8'hA3, 1'b0, 1'b1);
        @(posedge clk); #1;
        rd.req  = 1'b1;
        rd.addr = 4'd2;
        rd.len  = 4'd1;
        wait_busy(1'b1, "t5_first_busy");
        wait_busy(1'b0, "t5_first_done");
        @(posedge clk); #1;
        rd.req = 1'b0;
        @(negedge clk);
        check("t5_rearm_busy", 32'(rd.busy), 32'd1);
        wait_idle("t5b");

        // Reset mid-burst after the first beat, then a fresh single read.
        push_exp(8'hA0, 1'b0, 1'b0);
        start(4'd0, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid",   32'(rd.valid),     32'd0);
        check("t6_busy",    32'(rd.busy),      32'd0);
        check("t6_data",    32'(rd.data),      32'h00);
        check("t6_last",    32'(rd.last),      32'd0);
        check("t6_err",     32'(rd.err),       32'd0);
        check("t6_pending", 32'(exp_q.size()), 32'd0);

        push_exp(8'hA3, 1'b0, 1'b1);
        start(4'd3, 4'd0);
        @(negedge clk);
        check("t6b_load_valid", 32'(rd.valid), 32'd0);
        @(negedge clk);
        check("t6b_beat_valid", 32'(rd.valid), 32'd1);
        @(negedge clk);
        check("t6b_done_busy",  32'(rd.busy),  32'd0);
        wait_idle("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
